// File: rtl/writeback_unit.sv
// writeback_unit: register-file write-port producer.
// Arbitrates ALU and load results (load preferred, ALU guaranteed a slot
// every third contended cycle), extends load data, registers the write one
// cycle later, and tracks pending destinations for decode's hazard check.
//
// Handshake: a source's result is taken on a rising edge when its valid and
// ready are both high. Ready is combinational from the valids and the
// starvation counter; the winner always gets ready=1 because the write port
// never stalls. Data/rd presented while valid is low are ignored.
module writeback_unit #(
  parameter int BUS_DATA_WIDTH = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      issue_valid,
  input  logic [4:0]                issue_rd,
  input  logic                      alu_valid,
  input  logic [4:0]                alu_rd,
  input  logic [BUS_DATA_WIDTH-1:0] alu_result,
  output logic                      alu_ready,
  input  logic                      ld_valid,
  input  logic [4:0]                ld_rd,
  input  logic [BUS_DATA_WIDTH-1:0] ld_data,
  input  logic [1:0]                ld_size,
  input  logic                      ld_unsigned,
  output logic                      ld_ready,
  output logic                      write_en,
  output logic [4:0]                addressC,
  output logic [BUS_DATA_WIDTH-1:0] writeBack,
  output logic [31:0]               busy
);

  localparam int W = BUS_DATA_WIDTH;

  // Counts consecutive contended cycles the load has won; at 2 the ALU wins.
  logic [1:0]   r_starve;
  logic         r_write_en;
  logic [4:0]   r_address;
  logic [W-1:0] r_write_data;
  logic [31:0]  r_busy;

  logic         w_alu_acc;
  logic         w_ld_acc;
  logic         w_acc;
  logic [4:0]   w_sel_rd;
  logic [W-1:0] w_sel_data;
  logic [W-1:0] w_ld_ext;
  logic         w_do_write;
  logic [31:0]  w_set_mask;
  logic [31:0]  w_clr_mask;

  // Grant selection: single requester wins outright; under contention the
  // load wins until the counter reaches 2, then the ALU gets one slot.
  always_comb begin
    alu_ready = 1'b0;
    ld_ready  = 1'b0;
    if (!reset) begin
      if (alu_valid && ld_valid) begin
        if (r_starve == 2'd2) alu_ready = 1'b1;
        else                  ld_ready  = 1'b1;
      end else begin
        alu_ready = alu_valid;
        ld_ready  = ld_valid;
      end
    end
  end

  assign w_alu_acc = alu_valid && alu_ready;
  assign w_ld_acc  = ld_valid && ld_ready;
  assign w_acc     = w_alu_acc || w_ld_acc;

  // Load extension: pick the low 8/16/32/64 bits, then zero/sign extend.
  always_comb begin
    w_ld_ext = ld_data;
    case (ld_size)
      2'd0: w_ld_ext = ld_unsigned ? {{(W-8){1'b0}}, ld_data[7:0]}
                                   : {{(W-8){ld_data[7]}}, ld_data[7:0]};
      2'd1: w_ld_ext = ld_unsigned ? {{(W-16){1'b0}}, ld_data[15:0]}
                                   : {{(W-16){ld_data[15]}}, ld_data[15:0]};
      2'd2: w_ld_ext = ld_unsigned ? {{(W-32){1'b0}}, ld_data[31:0]}
                                   : {{(W-32){ld_data[31]}}, ld_data[31:0]};
      default: w_ld_ext = ld_data;
    endcase
  end

  // Mux the accepted result; only one source can be accepted per cycle.
  always_comb begin
    w_sel_rd   = 5'd0;
    w_sel_data = '0;
    if (w_alu_acc) begin
      w_sel_rd   = alu_rd;
      w_sel_data = alu_result;
    end else if (w_ld_acc) begin
      w_sel_rd   = ld_rd;
      w_sel_data = w_ld_ext;
    end
  end

  // Writes to x0 are consumed but never reach the register file.
  assign w_do_write = w_acc && (w_sel_rd != 5'd0);

  // Scoreboard masks: set from issue, clear from accepted result; set wins.
  always_comb begin
    w_set_mask = 32'd0;
    w_clr_mask = 32'd0;
    if (issue_valid && issue_rd != 5'd0) w_set_mask[issue_rd] = 1'b1;
    if (w_do_write)                      w_clr_mask[w_sel_rd] = 1'b1;
  end

  // Starvation counter: counts only contended load wins, otherwise clears.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_starve <= 2'd0;
    end else if (alu_valid && ld_valid && w_ld_acc) begin
      r_starve <= r_starve + 2'd1;
    end else begin
      r_starve <= 2'd0;
    end
  end

  // Registered write port: one-cycle strobe, address/data hold otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_write_en   <= 1'b0;
      r_address    <= 5'd0;
      r_write_data <= '0;
    end else begin
      r_write_en <= w_do_write;
      if (w_do_write) begin
        r_address    <= w_sel_rd;
        r_write_data <= w_sel_data;
      end
    end
  end

  // Pending-destination bits; bit 0 is forced low by construction of masks.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_busy <= 32'd0;
    end else begin
      r_busy <= ((r_busy & ~w_clr_mask) | w_set_mask) & 32'hFFFF_FFFE;
    end
  end

  assign write_en  = r_write_en;
  assign addressC  = r_address;
  assign writeBack = r_write_data;
  assign busy      = r_busy;

endmodule

// File: tb/tb_writeback_unit.sv
// tb_writeback_unit: directed stimulus with an expected-write queue that a
// negedge monitor drains whenever the DUT strobes write_en.
module tb_writeback_unit;

  localparam int W = 64;

  logic         clk = 1'b0;
  logic         reset;
  logic         issue_valid;
  logic [4:0]   issue_rd;
  logic         alu_valid;
  logic [4:0]   alu_rd;
  logic [W-1:0] alu_result;
  logic         alu_ready;
  logic         ld_valid;
  logic [4:0]   ld_rd;
  logic [W-1:0] ld_data;
  logic [1:0]   ld_size;
  logic         ld_unsigned;
  logic         ld_ready;
  logic         write_en;
  logic [4:0]   addressC;
  logic [W-1:0] writeBack;
  logic [31:0]  busy;

  // expected write = {addr, data}
  logic [W+4:0] exp_q[$];
  int errors = 0;
  int checks = 0;

  writeback_unit #(.BUS_DATA_WIDTH(W)) dut (
    .clk(clk), .reset(reset),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_result(alu_result),
    .alu_ready(alu_ready),
    .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data),
    .ld_size(ld_size), .ld_unsigned(ld_unsigned), .ld_ready(ld_ready),
    .write_en(write_en), .addressC(addressC), .writeBack(writeBack),
    .busy(busy)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // advance past the next rising edge; inputs are driven here
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    issue_valid = 0; issue_rd = 0;
    alu_valid = 0; alu_rd = 0; alu_result = 0;
    ld_valid = 0; ld_rd = 0; ld_data = 0; ld_size = 0; ld_unsigned = 0;
  endtask

  task automatic drive_load(input logic [4:0] rd, input logic [W-1:0] d,
                            input logic [1:0] sz, input logic uns,
                            input logic [W-1:0] exp_data, input string name);
    ld_valid = 1; ld_rd = rd; ld_data = d; ld_size = sz; ld_unsigned = uns;
    #1;
    check({name, " ld_ready"}, W'(ld_ready), 64'd1);
    exp_q.push_back({rd, exp_data});
    step();
  endtask

  // monitor: every write strobe must match the oldest expected write
  always @(negedge clk) begin
    if (!reset && write_en) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got addr=%0d data=0x%0h expected no write",
                 addressC, writeBack);
      end else begin
        logic [W+4:0] e;
        e = exp_q.pop_front();
        if ({addressC, writeBack} !== e) begin
          errors++;
          $display("FAIL write: got addr=%0d data=0x%0h expected addr=%0d data=0x%0h",
                   addressC, writeBack, e[W+4:W], e[W-1:0]);
        end
      end
    end
  end

  // arbitration grant pattern: 1 = ALU, 0 = load
  logic [5:0] grant_alu;

  initial begin
    grant_alu = 6'b100100;  // bit i for cycle i: L,L,A,L,L,A
    idle_inputs();
    reset = 1;
    alu_valid = 1; ld_valid = 1;
    #1;
    check("reset alu_ready", W'(alu_ready), 64'd0);
    check("reset ld_ready", W'(ld_ready), 64'd0);
    step(); step();
    check("reset write_en", W'(write_en), 64'd0);
    check("reset addressC", W'(addressC), 64'd0);
    check("reset writeBack", writeBack, 64'd0);
    check("reset busy", W'(busy), 64'd0);
    idle_inputs();
    reset = 0;
    step();

    // ALU single write with scoreboard
    issue_valid = 1; issue_rd = 7;
    step();
    issue_valid = 0; issue_rd = 0;
    check("busy7 set", W'(busy[7]), 64'd1);
    alu_valid = 1; alu_rd = 7; alu_result = 64'h1234;
    #1;
    check("alu single alu_ready", W'(alu_ready), 64'd1);
    check("alu single ld_ready", W'(ld_ready), 64'd0);
    exp_q.push_back({5'd7, 64'h1234});
    step();
    idle_inputs();
    check("alu single write_en", W'(write_en), 64'd1);
    check("busy7 cleared with write", W'(busy[7]), 64'd0);
    step();
    check("write_en one cycle", W'(write_en), 64'd0);
    check("addressC hold", W'(addressC), 64'd7);

    // load extension
    drive_load(5'd3, 64'h00000000000000F0, 2'd0, 1'b0, 64'hFFFFFFFFFFFFFFF0, "lb");
    drive_load(5'd4, 64'h00000000000000F0, 2'd0, 1'b1, 64'h00000000000000F0, "lbu");
    drive_load(5'd5, 64'h0000000000008001, 2'd1, 1'b0, 64'hFFFFFFFFFFFF8001, "lh");
    drive_load(5'd6, 64'h1234567880000000, 2'd2, 1'b0, 64'hFFFFFFFF80000000, "lw");
    drive_load(5'd8, 64'hABCDEF01FFFFFFFF, 2'd2, 1'b1, 64'h00000000FFFFFFFF, "lwu");
    drive_load(5'd12, 64'h8000000000000001, 2'd3, 1'b0, 64'h8000000000000001, "ld");
    drive_load(5'd13, 64'h0000000000007F55, 2'd1, 1'b1, 64'h0000000000007F55, "lhu");
    idle_inputs();
    step();

    // arbitration: both valid for 6 cycles
    for (int i = 0; i < 6; i++) begin
      alu_valid = 1; alu_rd = 10; alu_result = 64'h100 + W'(i);
      ld_valid = 1; ld_rd = 11; ld_data = 64'h200 + W'(i); ld_size = 2'd3;
      #1;
      check($sformatf("arb%0d alu_ready", i), W'(alu_ready), W'(grant_alu[i]));
      check($sformatf("arb%0d ld_ready", i), W'(ld_ready), W'(!grant_alu[i]));
      if (grant_alu[i]) exp_q.push_back({5'd10, 64'h100 + W'(i)});
      else              exp_q.push_back({5'd11, 64'h200 + W'(i)});
      step();
      check($sformatf("arb%0d write_en", i), W'(write_en), 64'd1);
    end
    idle_inputs();
    step();

    // x0 suppression
    alu_valid = 1; alu_rd = 0; alu_result = 64'hDEAD;
    #1;
    check("x0 alu_ready", W'(alu_ready), 64'd1);
    step();
    idle_inputs();
    check("x0 write_en", W'(write_en), 64'd0);
    check("x0 busy", W'(busy), 64'd0);
    check("x0 addressC", W'(addressC), 64'd10);
    check("x0 writeBack", writeBack, 64'h105);

    // scoreboard collision: clear and set of reg 9 on the same edge
    issue_valid = 1; issue_rd = 9;
    step();
    check("busy9 set", W'(busy[9]), 64'd1);
    ld_valid = 1; ld_rd = 9; ld_data = 64'h99; ld_size = 2'd3; ld_unsigned = 0;
    exp_q.push_back({5'd9, 64'h99});
    step();
    idle_inputs();
    check("collision busy9", W'(busy[9]), 64'd1);
    check("collision write_en", W'(write_en), 64'd1);
    check("collision addressC", W'(addressC), 64'd9);
    step();

    // reset mid-operation: accepted write of reg 5 must never appear
    alu_valid = 1; alu_rd = 5; alu_result = 64'hAA;
    #1;
    check("pre-reset alu_ready", W'(alu_ready), 64'd1);
    step();
    reset = 1;
    #1;
    check("mid reset write_en", W'(write_en), 64'd0);
    check("mid reset busy", W'(busy), 64'd0);
    check("mid reset writeBack", writeBack, 64'd0);
    check("mid reset alu_ready", W'(alu_ready), 64'd0);
    idle_inputs();
    step(); step();
    reset = 0;
    step(); step(); step();
    check("post reset write_en", W'(write_en), 64'd0);
    check("queue drained", W'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/writeback_unit.md
Name: writeback_unit

Overview:
- Producer side of the register file write port: drives `write_en`, `addressC` and `writeBack`.
- Arbitrates between ALU results and load-unit results, one write per cycle.
- Sign- or zero-extends load data.
- Keeps a 32-bit pending-destination scoreboard that decode uses for RAW hazard detection.

Parameters:
- BUS_DATA_WIDTH, 64, width of register data, ALU results and load data.

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- issue_valid  in  1  decode issued an instruction that writes rd
- issue_rd  in  5  destination register of the issued instruction
- alu_valid  in  1  ALU result available
- alu_rd  in  5  ALU destination register
- alu_result  in  BUS_DATA_WIDTH  ALU result
- alu_ready  out  1  ALU result accepted this cycle when alu_valid=1
- ld_valid  in  1  load data available
- ld_rd  in  5  load destination register
- ld_data  in  BUS_DATA_WIDTH  raw load data, right-aligned
- ld_size  in  2  0=byte, 1=half, 2=word, 3=double
- ld_unsigned  in  1  1=zero-extend, 0=sign-extend
- ld_ready  out  1  load accepted this cycle when ld_valid=1
- write_en  out  1  register file write strobe
- addressC  out  5  register file write address
- writeBack  out  BUS_DATA_WIDTH  register file write data
- busy  out  32  bit i=1 means register i has a pending write

Behaviour:
- Reset (asynchronous, any time): write_en=0, addressC=0, writeBack=0, busy=0, starvation counter=0.
  - Any result accepted in the cycle before reset is discarded.
  - alu_ready and ld_ready are 0 while reset is high.
- Acceptance: a result is accepted on a rising edge when valid&&ready. The write port never back-pressures, so the arbitration winner always sees ready=1.
- Arbitration (ready outputs are combinational from the valids and the counter):
  - Only one of alu_valid or ld_valid high: that source gets ready=1.
  - Both high, counter<2: load wins. ld_ready=1, alu_ready=0, counter increments.
  - Both high, counter==2: ALU wins. alu_ready=1, ld_ready=0, counter clears.
  - ALU accepted for any reason: counter clears. Cycle with alu_valid=0: counter clears.
- Latency: exactly one cycle. Result accepted at edge N appears on write_en/addressC/writeBack during cycle N+1. write_en is high for exactly that one cycle unless another accept follows.
- Register 0: an accepted result with rd=0 is consumed (ready honoured) but produces write_en=0. addressC and writeBack keep their previous values.
- No accept in a cycle: write_en=0 next cycle, addressC and writeBack hold.
- Load extension: take the low 8/16/32/64 bits of ld_data per ld_size, then zero- or sign-extend to BUS_DATA_WIDTH. Size 3 passes through unchanged.
- ALU results pass through unchanged.
- Scoreboard:
  - On an edge with issue_valid=1 and issue_rd!=0: busy[issue_rd] is set.
  - On an edge where a result with rd!=0 is accepted: busy[rd] is cleared at that edge, so busy drops in the same cycle write_en rises.
  - Set and clear to the same register on the same edge: set wins (newer producer pending).
  - busy[0] is always 0.
  - Busy is a single bit per register, not a count. Decode must not issue a second writer to a busy register; the unit does not check this.
- Unused inputs (rd/data with valid low) are ignored.

Test Plan:
- Reset mid-operation: alu_valid=1, rd=5, result 0xAA accepted, then reset asserted before the next edge → write_en=0, busy=0, writeBack=0 immediately; no write of reg 5 ever appears.
- ALU single write: issue rd=7, then alu_valid rd=7 result 0x1234 → alu_ready=1; next cycle write_en=1, addressC=7, writeBack=0x1234; busy[7] goes 1 then 0 together with the write_en rise.
- Load extension: ld_data=0x00000000000000F0, size=0, unsigned=0 → writeBack=0xFFFFFFFFFFFFFFF0. Same data with unsigned=1 → 0xF0. ld_data low half 0x8001, size=1, signed → 0xFFFFFFFFFFFF8001.
- Arbitration/starvation: alu_valid and ld_valid both held high for 6 cycles → grant order L,L,A,L,L,A; write_en high every cycle.
- x0 suppression: alu_valid rd=0 result 0xDEAD → alu_ready=1, write_en stays 0, busy stays 0, addressC unchanged.
- Scoreboard collision: busy[9]=1, then on one edge ld accept rd=9 and issue_rd=9 → write to 9 occurs, busy[9] remains 1.
